digit_feature_classifier: RTL

//  Parametrised multi-digit recogniser for the mono VIP path. Loads row/column

---
 rtl/digit_feature_classifier_if.sv | 14 +
 rtl/digit_feature_classifier.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_feature_classifier_if.sv
// Digit code stream: one classified digit per handshake, row-major order.
//   digit_valid  code/idx presented (held until accepted)
//   digit_ready  sink accepts when valid & ready
//   digit_code   0-9, or 4'hF for an unrecognised feature pattern
//   digit_idx    r*num_col + c of the presented code
interface digit_feature_classifier_if;
    logic       digit_valid;
    logic       digit_ready;
    logic [3:0] digit_code;
    logic [5:0] digit_idx;

    modport master (output digit_valid, digit_code, digit_idx, input digit_ready);
    modport slave  (input digit_valid, digit_code, digit_idx, output digit_ready);
endinterface

// File: rtl/digit_feature_classifier.sv
// Multi-digit recogniser: loads digit borders from the row/column projection
// RAMs, extracts crossing features during one frame scan, classifies each
// digit and streams the codes, then publishes a packed result word.
//   clk, rst_n                  clock, async active-low reset
//   feat_start, num_row/num_col job start and digit grid size
//   row/col_border_addr/data    border RAM ports (1-cycle read latency)
//   frame_start/end, pix_valid, xpos, ypos, monoc   pixel stream
//   dig                         digit code stream (valid/ready)
//   result, result_valid        packed codes (idx0 in [3:0]), update pulse
//   busy                        high whenever the FSM is not idle
module digit_feature_classifier #(
    parameter  int unsigned MAX_ROW = 2,
    parameter  int unsigned MAX_COL = 4,
    parameter  int unsigned XW      = 11,
    localparam int unsigned NUM_W   = MAX_ROW * MAX_COL * 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      feat_start,
    input  logic [3:0]                num_row,
    input  logic [3:0]                num_col,
    output logic [XW-1:0]             row_border_addr,
    input  logic [XW-1:0]             row_border_data,
    output logic [XW-1:0]             col_border_addr,
    input  logic [XW-1:0]             col_border_data,
    input  logic                      frame_start,
    input  logic                      frame_end,
    input  logic                      pix_valid,
    input  logic [XW-1:0]             xpos,
    input  logic [XW-1:0]             ypos,
    input  logic                      monoc,
    digit_feature_classifier_if.master dig,
    output logic [NUM_W-1:0]          result,
    output logic                      result_valid,
    output logic                      busy
);
    localparam int unsigned PW = XW + 7;
    localparam int unsigned RW = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
    localparam int unsigned CW = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] ARM  = 3'd2;
    localparam logic [2:0] SCAN = 3'd3;
    localparam logic [2:0] EMIT = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [3:0]       nr, nc;
    logic [4:0]       ld_cnt;
    logic [XW-1:0]    row_top [MAX_ROW];
    logic [XW-1:0]    row_bot [MAX_ROW];
    logic [XW-1:0]    y1 [MAX_ROW];
    logic [XW-1:0]    y2 [MAX_ROW];
    logic [XW-1:0]    col_l [MAX_COL];
    logic [XW-1:0]    col_r [MAX_COL];
    logic [XW-1:0]    cent [MAX_COL];
    logic [1:0]       ycnt [MAX_ROW][MAX_COL];
    logic [3:0]       xf [MAX_ROW][MAX_COL];   // {x1_l, x1_r, x2_l, x2_r}
    logic             vprev [MAX_COL];
    logic             have_last, last_mono;
    logic [XW-1:0]    last_y;
    logic [RW-1:0]    er;
    logic [CW-1:0]    ec;
    logic [NUM_W-1:0] res_acc;

    // Job sizing and handshake decode
    logic [3:0]       nr_in_c, nc_in_c;
    logic [4:0]       ld_len_c, cap_c;
    logic [6:0]       total_c;
    logic             accept_c, last_c, col_wrap_c, fall_h_c;
    logic [RW-1:0]    er_nxt_c;
    logic [CW-1:0]    ec_nxt_c;
    logic [3:0]       code_first_c, code_next_c;
    logic [NUM_W-1:0] res_wr_c;

    assign nr_in_c    = (num_row > 4'(MAX_ROW)) ? 4'(MAX_ROW) : num_row;
    assign nc_in_c    = (num_col > 4'(MAX_COL)) ? 4'(MAX_COL) : num_col;
    assign ld_len_c   = ({nr, 1'b0} > {nc, 1'b0}) ? {nr, 1'b0} : {nc, 1'b0};
    assign cap_c      = ld_cnt - 5'd1;
    assign total_c    = 7'(nr) * 7'(nc);
    assign accept_c   = dig.digit_valid & dig.digit_ready;
    assign last_c     = (7'(dig.digit_idx) + 7'd1 == total_c);
    assign col_wrap_c = (4'(ec) + 4'd1 == nc);
    // On the last digit the successor is never used; stay on the current one
    assign er_nxt_c   = (last_c || !col_wrap_c) ? er : er + RW'(1);
    assign ec_nxt_c   = last_c ? ec : (col_wrap_c ? '0 : ec + CW'(1));
    assign fall_h_c   = have_last && (last_y == ypos) && last_mono && !monoc;

    function automatic logic [3:0] classify(input logic [1:0] yc, input logic [3:0] x);
        case ({yc, x})
            6'b10_1111: return 4'd0;
            6'b01_1010: return 4'd1;
            6'b11_0110: return 4'd2;
            6'b11_0101: return 4'd3;
            6'b10_1110: return 4'd4;
            6'b11_1001: return 4'd5;
            6'b11_1011: return 4'd6;
            6'b10_0110: return 4'd7;
            6'b11_1111: return 4'd8;
            6'b11_1101: return 4'd9;
            default:    return 4'hF;
        endcase
    endfunction

    assign code_first_c = classify(ycnt[0][0], xf[0][0]);
    assign code_next_c  = classify(ycnt[er_nxt_c][ec_nxt_c], xf[er_nxt_c][ec_nxt_c]);

    // Result word including the code being accepted this cycle
    always_comb begin
        res_wr_c = res_acc;
        res_wr_c[4*int'(dig.digit_idx) +: 4] = dig.digit_code;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (feat_start && nr_in_c != 4'd0 && nc_in_c != 4'd0) state_nxt = LOAD;
            LOAD: if (ld_cnt == ld_len_c + 5'd2) state_nxt = ARM;
            ARM:  if (frame_start) state_nxt = SCAN;
            SCAN: if (frame_end) state_nxt = EMIT;
            EMIT: if (accept_c && last_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: border load, feature extraction, code emission
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nr <= '0; nc <= '0; ld_cnt <= '0;
            row_border_addr <= '0; col_border_addr <= '0;
            have_last <= 1'b0; last_mono <= 1'b0; last_y <= '0;
            er <= '0; ec <= '0; res_acc <= '1;
            dig.digit_valid <= 1'b0; dig.digit_code <= '0; dig.digit_idx <= '0;
            result <= '1; result_valid <= 1'b0; busy <= 1'b0;
            for (int r = 0; r < int'(MAX_ROW); r++) begin
                row_top[r] <= '0; row_bot[r] <= '0; y1[r] <= '0; y2[r] <= '0;
                for (int c = 0; c < int'(MAX_COL); c++) begin
                    ycnt[r][c] <= '0; xf[r][c] <= '0;
                end
            end
            for (int c = 0; c < int'(MAX_COL); c++) begin
                col_l[c] <= '0; col_r[c] <= '0; cent[c] <= '0; vprev[c] <= 1'b1;
            end
        end else begin
            result_valid <= 1'b0;
            busy         <= (state_nxt != IDLE);
            case (state)
                IDLE: if (feat_start) begin
                    nr <= nr_in_c; nc <= nc_in_c; ld_cnt <= '0;
                    row_border_addr <= '0; col_border_addr <= '0;
                    if (nr_in_c == 4'd0 || nc_in_c == 4'd0) begin
                        result <= '1; result_valid <= 1'b1;
                    end
                end
                LOAD: begin
                    ld_cnt <= ld_cnt + 5'd1;
                    if (ld_cnt + 5'd1 < {nr, 1'b0}) row_border_addr <= XW'(ld_cnt + 5'd1);
                    if (ld_cnt + 5'd1 < {nc, 1'b0}) col_border_addr <= XW'(ld_cnt + 5'd1);
                    if (ld_cnt == 5'd0) begin
                        for (int r = 0; r < int'(MAX_ROW); r++)
                            for (int c = 0; c < int'(MAX_COL); c++) begin
                                ycnt[r][c] <= '0; xf[r][c] <= '0;
                            end
                    end else if (ld_cnt <= ld_len_c) begin
                        // Data for the address issued one cycle earlier
                        if (cap_c < {nr, 1'b0}) begin
                            if (cap_c[0]) row_bot[RW'(cap_c[4:1])] <= row_border_data;
                            else          row_top[RW'(cap_c[4:1])] <= row_border_data;
                        end
                        if (cap_c < {nc, 1'b0}) begin
                            if (cap_c[0]) col_r[CW'(cap_c[4:1])] <= col_border_data;
                            else          col_l[CW'(cap_c[4:1])] <= col_border_data;
                        end
                    end else if (ld_cnt == ld_len_c + 5'd1) begin
                        // Scan lines at ~0.41 and ~0.67 of the digit height
                        for (int r = 0; r < int'(MAX_ROW); r++) begin
                            y1[r] <= XW'((PW'(row_bot[r]) * PW'(26) + PW'(row_top[r]) * PW'(38)) >> 6);
                            y2[r] <= XW'((PW'(row_bot[r]) * PW'(43) + PW'(row_top[r]) * PW'(21)) >> 6);
                        end
                        for (int c = 0; c < int'(MAX_COL); c++)
                            cent[c] <= XW'((PW'(col_l[c]) + PW'(col_r[c])) >> 1);
                    end
                end
                ARM: if (frame_start) begin
                    have_last <= 1'b0;
                    for (int c = 0; c < int'(MAX_COL); c++) vprev[c] <= 1'b1;
                end
                SCAN: begin
                    if (pix_valid) begin
                        have_last <= 1'b1; last_mono <= monoc; last_y <= ypos;
                        for (int r = 0; r < int'(MAX_ROW); r++)
                            for (int c = 0; c < int'(MAX_COL); c++)
                                if (4'(r) < nr && 4'(c) < nc &&
                                    ypos >= row_top[r] && ypos <= row_bot[r] &&
                                    xpos >= col_l[c] && xpos <= col_r[c]) begin
                                    if (fall_h_c && ypos == y1[r]) begin
                                        if (xpos <= cent[c]) xf[r][c][3] <= 1'b1;
                                        else                 xf[r][c][2] <= 1'b1;
                                    end
                                    if (fall_h_c && ypos == y2[r]) begin
                                        if (xpos <= cent[c]) xf[r][c][1] <= 1'b1;
                                        else                 xf[r][c][0] <= 1'b1;
                                    end
                                    // Centre column: count white->black, top line sees white above
                                    if (xpos == cent[c]) begin
                                        if (!monoc && (ypos == row_top[r] || vprev[c]) &&
                                            ycnt[r][c] != 2'd3)
                                            ycnt[r][c] <= ycnt[r][c] + 2'd1;
                                        vprev[c] <= monoc;
                                    end
                                end
                    end
                    if (frame_end) begin
                        dig.digit_valid <= 1'b1; dig.digit_code <= code_first_c;
                        dig.digit_idx <= '0; er <= '0; ec <= '0; res_acc <= '1;
                    end
                end
                EMIT: if (accept_c) begin
                    res_acc <= res_wr_c;
                    if (last_c) begin
                        dig.digit_valid <= 1'b0;
                        result <= res_wr_c; result_valid <= 1'b1;
                    end else begin
                        er <= er_nxt_c; ec <= ec_nxt_c;
                        dig.digit_idx  <= dig.digit_idx + 6'd1;
                        dig.digit_code <= code_next_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
